ram_fifo_ctrl: RTL

- Synchronous FIFO controller that owns one dual_port_sync_ram (16x8 default). It drives port A as the write port and port B as the read port.
- Presents valid/ready streams on both sides and hides the RAM's 1-cycle registered read behind a 2-entry output skid buffer.
- Sits directly upstream of the RAM, between a producer stream and a consumer stream.

---
 rtl/ram_fifo_ctrl_pkg.sv | 17 +
 rtl/dual_port_sync_ram.sv | 29 ++
 rtl/fifo_out_skid.sv | 52 +++++
 rtl/ram_fifo_ctrl.sv | 97 +++++++++
 4 files changed

// File: rtl/ram_fifo_ctrl_pkg.sv
// Shared defaults and derived-width helpers for the RAM-backed FIFO controller.
package ram_fifo_ctrl_pkg;

    localparam int unsigned DATA_W_DEF   = 8;
    localparam int unsigned ADDR_W_DEF   = 4;
    localparam int unsigned AF_LEVEL_DEF = 12;

    // Pointers carry one extra wrap bit; counts must reach DEPTH+2.
    function automatic int unsigned ptr_width(input int unsigned addr_w);
        return addr_w + 1;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned addr_w);
        return addr_w + 2;
    endfunction

endpackage

// File: rtl/dual_port_sync_ram.sv
// Dual-port synchronous RAM with registered read data on both ports.
module dual_port_sync_ram #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] din_a,
    output logic [DATA_W-1:0] dout_a,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] din_b,
    output logic [DATA_W-1:0] dout_b
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we_a) mem[addr_a] <= din_a;
        dout_a <= mem[addr_a];
    end

    always_ff @(posedge clk) begin
        if (we_b) mem[addr_b] <= din_b;
        dout_b <= mem[addr_b];
    end

endmodule

// File: rtl/fifo_out_skid.sv
// Two-entry in-order output buffer; entry 0 is the stream head.
module fifo_out_skid
    import ram_fifo_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fill,
    input  logic [DATA_W-1:0] fill_data,
    input  logic              pop,
    output logic [1:0]        skid_cnt,
    output logic              head_valid,
    output logic [DATA_W-1:0] head_data
);

    logic              v1;
    logic [DATA_W-1:0] e1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_valid <= 1'b0;
            head_data  <= '0;
            v1         <= 1'b0;
            e1         <= '0;
        end else if (pop) begin
            // Popping shifts entry 1 forward; a fill lands behind whatever remains.
            if (v1) begin
                head_data <= e1;
                if (fill) e1 <= fill_data;
                v1 <= fill;
            end else begin
                if (fill) head_data <= fill_data;
                head_valid <= fill;
                v1         <= 1'b0;
            end
        end else if (fill) begin
            if (!head_valid) begin
                head_data  <= fill_data;
                head_valid <= 1'b1;
            end else begin
                e1 <= fill_data;
                v1 <= 1'b1;
            end
        end
    end

    always_comb begin
        skid_cnt = {1'b0, head_valid} + {1'b0, v1};
    end

endmodule

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller around a dual-port sync RAM with a 2-entry output skid.
// Optional FIFO_ALMOST_EN adds a registered almost_full output.
module ram_fifo_ctrl
    import ram_fifo_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned AF_LEVEL = AF_LEVEL_DEF
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [DATA_W-1:0]             s_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [DATA_W-1:0]             m_data,
    output logic [cnt_width(ADDR_W)-1:0]  count,
    output logic                          ram_we_a,
    output logic [ADDR_W-1:0]             ram_addr_a,
    output logic [DATA_W-1:0]             ram_din_a,
    output logic [ADDR_W-1:0]             ram_addr_b,
    input  logic [DATA_W-1:0]             ram_dout_b
`ifdef FIFO_ALMOST_EN
    ,
    output logic                          almost_full
`endif
);

    localparam int unsigned DEPTH = 2**ADDR_W;
    localparam int unsigned PTR_W = ptr_width(ADDR_W);
    localparam int unsigned CNT_W = cnt_width(ADDR_W);

    logic [PTR_W-1:0] wr_ptr, rd_ptr, occ;
    logic [CNT_W-1:0] occ_next;
    logic [1:0]       skid_cnt, skid_after_pop;
    logic             rd_pend, push, pop, rd_issue, s_ready_next;

    always_comb begin
        push           = s_valid & s_ready;
        pop            = m_valid & m_ready;
        occ            = wr_ptr - rd_ptr;
        skid_after_pop = skid_cnt - {1'b0, pop};
        // Issue only if the skid will still have room when this read returns.
        rd_issue       = (occ != '0) &&
                         (({1'b0, skid_after_pop} + {2'b00, rd_pend}) < 3'd2);
        occ_next       = CNT_W'(occ) + CNT_W'(push) - CNT_W'(rd_issue);
        s_ready_next   = occ_next < CNT_W'(DEPTH);
        count          = CNT_W'(occ) + CNT_W'(rd_pend) + CNT_W'(skid_cnt);
        ram_we_a       = push;
        ram_addr_a     = wr_ptr[ADDR_W-1:0];
        ram_din_a      = s_data;
        ram_addr_b     = rd_ptr[ADDR_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            rd_pend <= 1'b0;
            s_ready <= 1'b0;
        end else begin
            wr_ptr  <= wr_ptr + PTR_W'(push);
            rd_ptr  <= rd_ptr + PTR_W'(rd_issue);
            rd_pend <= rd_issue;
            s_ready <= s_ready_next;
        end
    end

`ifdef FIFO_ALMOST_EN
    logic [CNT_W-1:0] count_next;

    always_comb begin
        count_next = count + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) almost_full <= 1'b0;
        else        almost_full <= count_next >= CNT_W'(AF_LEVEL);
    end
`else
`endif

    fifo_out_skid #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk        (clk),
        .rst_n      (rst_n),
        .fill       (rd_pend),
        .fill_data  (ram_dout_b),
        .pop        (pop),
        .skid_cnt   (skid_cnt),
        .head_valid (m_valid),
        .head_data  (m_data)
    );

endmodule
